// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: the hex decode
// table, the scan state encoding and the all-segments-off pattern.
package seven_seg_pkg;

    // Active-high segment patterns (bit order g..a, bit0 = a) for hex 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    // Active-low bus value with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // DEAD: all digits off between digits; ON: one digit lit.
    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scanState_e;

endpackage

// File: rtl/seven_seg_scan_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with dead time
// between digits and shadow-registered display data.
// Optional build macro: SEVEN_SEG_SCAN_ZERO_SUPPRESS_EN blanks leading
// zero digits (digit 0 always shown).
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_n
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadowValue_q;
    logic [NUM_DIGITS-1:0]   shadowDp_q;
    logic [NUM_DIGITS-1:0]   shadowBlank_q;

    scanState_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [6:0]              segN_q;
    logic                    dpN_q;
    logic [NUM_DIGITS-1:0]   digitN_q;

    logic [3:0]              curNibble;
    logic                    curDp;
    logic                    curBlank;
    logic                    suppress;
    logic [6:0]              curSeg;
    logic                    dark_d;

    // Shadow registers: display data only changes on a load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadowValue_q <= '0;
            shadowDp_q    <= '0;
            shadowBlank_q <= '1;
        end else if (load) begin
            shadowValue_q <= value;
            shadowDp_q    <= dp;
            shadowBlank_q <= blank;
        end
    end

    // Select the nibble, decimal point and blank request of the scanned digit.
    always_comb begin
        curNibble = 4'h0;
        curDp     = 1'b0;
        curBlank  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                curNibble = shadowValue_q[4*i +: 4];
                curDp     = shadowDp_q[i];
                curBlank  = shadowBlank_q[i];
            end
        end
    end

`ifdef SEVEN_SEG_SCAN_ZERO_SUPPRESS_EN
    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        logic upperZero;
        upperZero = 1'b1;
        suppress  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upperZero = upperZero && (shadowValue_q[4*i +: 4] == 4'h0);
            if ((i != 0) && (idx_q == IDX_W'(i)) && upperZero) begin
                suppress = 1'b1;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign dark_d = curBlank | suppress;

    hex_to_seg7 u_hexToSeg7 (
        .nibble_i (curNibble),
        .seg_o    (curSeg)
    );

    // Scan FSM; pins are latched at the start of each ON phase so a lit digit never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DEAD;
            cnt_q    <= '0;
            idx_q    <= '0;
            segN_q   <= SEG_OFF;
            dpN_q    <= 1'b1;
            digitN_q <= '1;
        end else begin
            if (state_q == ON) begin
                if (cnt_q == '0) begin
                    digitN_q <= ~(NUM_DIGITS'(1) << idx_q);
                    segN_q   <= dark_d ? SEG_OFF : ~curSeg;
                    dpN_q    <= dark_d ? 1'b1 : ~curDp;
                end
            end else begin
                digitN_q <= '1;
                segN_q   <= SEG_OFF;
                dpN_q    <= 1'b1;
            end

            case (state_q)
                DEAD: begin
                    if ((DEAD_CYCLES == 0) || (cnt_q == DEAD_LAST)) begin
                        state_q <= ON;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_q <= (DEAD_CYCLES == 0) ? ON : DEAD;
                        cnt_q   <= '0;
                        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= DEAD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign seg_n   = segN_q;
    assign dp_n    = dpN_q;
    assign digit_n = digitN_q;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Captures a packed hex value on a load strobe into a shadow register.
- Scans the digits round-robin, with a programmable dead time between digits to suppress ghosting.
- Drives active-low segment, decimal-point and digit-enable lines.
- Sits between status/debug registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIGIT_CYCLES, 50000, clk cycles each digit is lit (>=2)
DEAD_CYCLES, 500, clk cycles all digits are off between digits (>=0, < DIGIT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
value  in  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
dp  in  NUM_DIGITS  decimal-point request per digit, 1 = lit
blank  in  NUM_DIGITS  per-digit blank request, 1 = digit dark
load  in  1  capture value/dp/blank into shadow registers
seg_n  out  7  segments g..a, active-low (bit0 = a)
dp_n  out  1  decimal point, active-low
digit_n  out  NUM_DIGITS  digit enables, active-low, at most one low

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - Shadow registers cleared (value 0, dp 0, blank all-ones).
  - Scan index = 0, state = DEAD, cycle counter = 0.
  - Outputs seg_n = 7'h7F, dp_n = 1, digit_n = all-ones.
- Load: on a clk edge with load=1, the shadow registers take the inputs. The new data is visible from the next ON phase. Inputs are ignored while load=0.
- State machine, with cycle counter cnt:
  - DEAD: all outputs inactive. When cnt == DEAD_CYCLES-1, or immediately if DEAD_CYCLES == 0, go to ON and clear cnt.
  - ON: digit_n[idx] = 0. seg_n = ~decode(nibble idx). dp_n = ~dp[idx]. If blank[idx] = 1, seg_n = 7'h7F and dp_n = 1 while digit_n[idx] stays low. When cnt == DIGIT_CYCLES-1, go to DEAD, clear cnt, and set idx = (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Wrap: idx wraps from NUM_DIGITS-1 to 0 with no extra cycle.
- Output timing: all outputs are registered, so there is one cycle of latency from a state/idx change to the pins. digit_n and seg_n change on the same edge, and there is never a cycle where a new digit is lit with old segments.
- Load collision: load in the same cycle as an ON→DEAD transition is legal. The next ON phase uses the new data.
- Mid-frame load: load during an ON phase does not alter the currently lit digit until the next ON phase. Segments stay stable within a phase.
- Reset mid-scan returns to the reset state on the next edge.
- Counter sizing: width = $clog2(DIGIT_CYCLES).
- Decode table (active-high, gfedcba), hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 58 5E 79 71.

Optional Feature:
Macro SEVEN_SEG_SCAN_ZERO_SUPPRESS_EN.
- Defined: a digit whose nibble is 0, and whose every more-significant digit is also 0, is treated as blanked (dark, dp also suppressed). Digit 0 is never suppressed, so the value 0 shows "0".
- Not defined: only the blank input blanks digits; zeros are always shown.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry decode constant table;
  - the scan state enum (DEAD, ON);
  - constant SEG_OFF = 7'h7F.
- One natural combinational sub-module, hex_to_seg7 (4-bit nibble → 7-bit active-high pattern from the package table). It is instantiated once, on the muxed nibble.

Test Plan:
1. Reset: hold rst 3 cycles → seg_n=7F, dp_n=1, digit_n=all-ones. First digit_n[0] low exactly DEAD_CYCLES+1 cycles after rst release.
2. Scan (NUM_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2): load value=16'h12AF, blank=0 → digit 0 seg_n=~71, then ~77, ~5B, ~06. Each is low 8 cycles, with 2 dark cycles between digits, then wraps to digit 0.
3. Blank/dp: blank=4'b0100, dp=4'b0001 → digit 2 enabled but seg_n=7F, dp_n=1. Digit 0 shows dp_n=0.
4. Mid-phase load: load value 16'h0000→16'hFFFF halfway through the digit 1 ON phase → digit 1 keeps ~3F until the phase ends. Digit 2 shows ~71.
5. Zero-suppress (macro defined): value=16'h0050 → digits 3 and 2 dark; digits 1 and 0 show 5 and 0. value=0 → only digit 0 shows "0".
6. Reset during ON of digit 2 → next cycle outputs inactive, idx restarts at 0.
